// File: rtl/cpu_pkg.sv
// Shared cpu-system constants: bus widths and the 2-bit instruction opcodes.
// Blocks downstream of the cpu import this so widths never drift apart.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [1:0]        opcode_t;

    localparam opcode_t IN  = 2'b00;
    localparam opcode_t OUT = 2'b01;
    localparam opcode_t ST  = 2'b10;
    localparam opcode_t LD  = 2'b11;

endpackage

// File: rtl/cpu_out_fifo_if.sv
// Bundle between the cpu OUT path, the output FIFO and its consumer.
// The slave modport is the FIFO; the master modport is the cpu/consumer side.
interface cpu_out_fifo_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    word_t            wr_data;
    logic             full;
    logic             ovf;
    logic             clr_ovf;
    logic [CNT_W-1:0] count;
    word_t            out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  wr_en, wr_data, clr_ovf, out_ready,
        output full, ovf, count, out_data, out_valid
    );

    modport master (
        output wr_en, wr_data, clr_ovf, out_ready,
        input  full, ovf, count, out_data, out_valid
    );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage for the output FIFO: synchronous write, asynchronous read.
module fifo_regfile
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers and count guard every read, and
    // a reset term here would turn the array into a wide mux of reset flops.
    // NOTE: non-blocking assignment keeps the write ordered after every reader of
    // this edge, so a same-cycle read sees the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_out_fifo.sv
// Output-port FIFO behind the cpu OUT instruction: show-ahead valid/ready drain,
// occupancy/full status and a sticky overflow flag for dropped pushes.
module cpu_out_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    cpu_out_fifo_if.slave bus
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_q;
    logic             full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             drop;
    word_t            head;

    // Status comes only from registered count, never from this cycle's strobes.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);

    assign push = bus.wr_en & ~full;
    assign drop = bus.wr_en & full;
    assign pop  = not_empty & bus.out_ready;

    fifo_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // NOTE: default assignment first so every path drives count_nxt (no latch).
    always_comb begin
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
        end
    end

    // A dropped push outranks a clear requested on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.full      = full;
    assign bus.ovf       = ovf_q;
    assign bus.count     = count_q;
    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? head : '0;

endmodule

// File: tb/tb_cpu_out_fifo.sv
// Scenario bench for cpu_out_fifo: a queue of pushed words is the reference;
// each accepted pop is checked against its head.
module tb_cpu_out_fifo;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    cpu_out_fifo_if #(.DEPTH(DEPTH)) bus ();

    cpu_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int    total = 0;
    int    bad   = 0;
    int    rx_cnt = 0;
    word_t sb[$];
    logic  ovf_m = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge: drives one cycle of inputs, compares state against the
    // reference queue, then advances the reference across the next posedge.
    task automatic cycle(input logic we, input word_t d, input logic rdy, input logic clr);
        logic pop_m, push_m, drop_m;
        bus.wr_en     = we;
        bus.wr_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        #1;
        total++;
        if (bus.count !== CNT_W'(sb.size())) begin
            bad++;
            $display("FAIL count: got %0d expected %0d", bus.count, sb.size());
        end
        total++;
        if (bus.out_valid !== (sb.size() != 0)) begin
            bad++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, sb.size() != 0);
        end
        total++;
        if (bus.full !== (sb.size() == DEPTH)) begin
            bad++;
            $display("FAIL full: got %b expected %b", bus.full, sb.size() == DEPTH);
        end
        total++;
        if (bus.ovf !== ovf_m) begin
            bad++;
            $display("FAIL ovf: got %b expected %b", bus.ovf, ovf_m);
        end
        if (sb.size() == 0) begin
            total++;
            if (bus.out_data !== '0) begin
                bad++;
                $display("FAIL idle_data: got %0d expected 0", bus.out_data);
            end
        end
        pop_m  = (sb.size() != 0) && rdy;
        push_m = we && (sb.size() < DEPTH);
        drop_m = we && (sb.size() == DEPTH);
        if (pop_m) begin
            total++;
            if (bus.out_data !== sb[0]) begin
                bad++;
                $display("FAIL pop_data: got %0d expected %0d", bus.out_data, sb[0]);
            end
            void'(sb.pop_front());
            rx_cnt++;
        end
        if (push_m) sb.push_back(d);
        if (drop_m) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'hAA; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%0d valid=%b expected 0/0", bus.count, bus.out_valid);
        end
        total++;
        if (bus.out_data !== '0 || bus.ovf !== 1'b0 || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: data=%0d ovf=%b full=%b expected 0/0/0",
                     bus.out_data, bus.ovf, bus.full);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.count !== '0) begin
            bad++;
            $display("FAIL reset_no_push: count=%0d expected 0", bus.count);
        end
        sb.delete();
        ovf_m = 1'b0;
    endtask

    task automatic test_fill();
        word_t vals[4] = '{8'd7, 8'd9, 8'd3, 8'd5};
        foreach (vals[i]) cycle(1'b1, vals[i], 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (bus.full !== 1'b1 || bus.count !== CNT_W'(4) || bus.out_data !== 8'd7) begin
            bad++;
            $display("FAIL fill: full=%b count=%0d data=%0d expected 1/4/7",
                     bus.full, bus.count, bus.out_data);
        end
        cycle(1'b1, 8'd8, 1'b0, 1'b0);
        #1;
        total++;
        if (bus.ovf !== 1'b1 || bus.count !== CNT_W'(4)) begin
            bad++;
            $display("FAIL fill_ovf: ovf=%b count=%0d expected 1/4", bus.ovf, bus.count);
        end
    endtask

    task automatic test_drain();
        word_t exp_order[4] = '{8'd7, 8'd9, 8'd3, 8'd5};
        foreach (exp_order[i]) begin
            #1;
            total++;
            if (bus.out_data !== exp_order[i]) begin
                bad++;
                $display("FAIL drain_order[%0d]: got %0d expected %0d", i, bus.out_data, exp_order[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL drain_end: valid=%b ovf=%b expected 0/1", bus.out_valid, bus.ovf);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        int    next = 1;
        int    rx_start = rx_cnt;
        int    cycles = 0;
        logic  stalled = 1'b0;
        word_t held = '0;
        logic  we, rdy;
        while ((next <= 10 || sb.size() != 0) && cycles < 200) begin
            #1;
            if (stalled) begin
                total++;
                if (bus.out_data !== held) begin
                    bad++;
                    $display("FAIL wrap_stall: got %0d expected %0d", bus.out_data, held);
                end
            end
            we  = (next <= 10) && (sb.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            stalled = (sb.size() != 0) && !rdy;
            held = bus.out_data;
            cycle(we, word_t'(next), rdy, 1'b0);
            if (we) next++;
            cycles++;
        end
        total++;
        if (rx_cnt - rx_start !== 10) begin
            bad++;
            $display("FAIL wrap_count: received %0d expected 10 (cycles=%0d)", rx_cnt - rx_start, cycles);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 8'd11, 1'b0, 1'b0);
        cycle(1'b1, 8'd12, 1'b0, 1'b0);
        cycle(1'b1, 8'd13, 1'b1, 1'b0);
        cycle(1'b1, 8'd14, 1'b1, 1'b0);
        #1;
        total++;
        if (bus.count !== CNT_W'(2)) begin
            bad++;
            $display("FAIL concurrent_count: got %0d expected 2", bus.count);
        end
        cycle(1'b1, 8'd15, 1'b0, 1'b0);
        cycle(1'b1, 8'd16, 1'b0, 1'b0);
        // Full: push dropped, pop completes, ovf set despite clr in the same cycle.
        cycle(1'b1, 8'd99, 1'b1, 1'b1);
        #1;
        total++;
        if (bus.count !== CNT_W'(3) || bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL full_concurrent: count=%0d ovf=%b expected 3/1", bus.count, bus.ovf);
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8'd21, 1'b0, 1'b0);
        cycle(1'b1, 8'd22, 1'b0, 1'b0);
        cycle(1'b1, 8'd23, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b count=%0d expected 0/0", bus.out_valid, bus.count);
        end
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        ovf_m = 1'b0;
        cycle(1'b1, 8'd42, 1'b0, 1'b0);
        #1;
        total++;
        if (bus.out_data !== 8'd42 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_push: data=%0d valid=%b expected 42/1", bus.out_data, bus.out_valid);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
